// File: rtl/color_round_ctrl_pkg.sv
// color_round_ctrl_pkg: shared state encoding, palette geometry and palette lookup helper
package color_round_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
  localparam int COLOR_W = 3;
  localparam int NUM_PLATS = 4;
  localparam int PALETTE_W = COLOR_W * NUM_PLATS;
  localparam int PLAT_IDX_W = 2;
  function automatic logic [COLOR_W-1:0] plat_color(input logic [PALETTE_W-1:0] pal, input logic [PLAT_IDX_W-1:0] idx);
    return pal[COLOR_W*idx +: COLOR_W];
  endfunction
endpackage

// File: rtl/color_round_ctrl_if.sv
// color_round_ctrl_if: game inputs (tick, start, randomiser colours, landings) and registered game outputs
//   master drives tick/start/new_color_*/land_*, slave (the controller) drives everything else
interface color_round_ctrl_if #(parameter int SCORE_W = 8);
  import color_round_ctrl_pkg::*;
  logic tick;
  logic start;
  logic [PALETTE_W-1:0] new_color_plats;
  logic [COLOR_W-1:0] new_color_ball;
  logic land_valid;
  logic [PLAT_IDX_W-1:0] land_plat;
  logic [PALETTE_W-1:0] plat_colors;
  logic [COLOR_W-1:0] ball_color;
  logic [SCORE_W-1:0] score;
  logic [1:0] lives;
  logic [7:0] timer;
  state_t state;
  logic round_hit;
  logic round_miss;
  logic game_over;
  modport master (
    output tick, start, new_color_plats, new_color_ball, land_valid, land_plat,
    input plat_colors, ball_color, score, lives, timer, state, round_hit, round_miss, game_over
  );
  modport slave (
    input tick, start, new_color_plats, new_color_ball, land_valid, land_plat,
    output plat_colors, ball_color, score, lives, timer, state, round_hit, round_miss, game_over
  );
endinterface

// File: rtl/color_round_ctrl_round_timer.sv
// color_round_ctrl_round_timer: loadable 8-bit down-counter with tick enable and expire flag
//   load/load_val: reload; en: one tick; count: ticks left; expire: this tick consumes the last one
module color_round_ctrl_round_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       expire
);
  assign expire = en && count == 8'd1;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 8'd1;
  end
endmodule

// File: rtl/color_round_ctrl.sv
// color_round_ctrl: latches colours per round, judges landings, keeps score/lives/timer, flags game over
//   clk, reset (sync, active-high); bus: slave side of color_round_ctrl_if
module color_round_ctrl #(
  parameter logic [7:0] ROUND_TICKS = 8'd120,
  parameter logic [1:0] START_LIVES = 2'd3,
  parameter int         SCORE_W     = 8
) (
  input logic clk,
  input logic reset,
  color_round_ctrl_if.slave bus
);
  import color_round_ctrl_pkg::*;
  logic expire;
  logic match;
  assign match = plat_color(bus.plat_colors, bus.land_plat) == bus.ball_color;
  // a landing in the same cycle as a tick takes priority, so the tick never reaches the timer
  color_round_ctrl_round_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (bus.state == LOAD),
    .en       (bus.state == PLAY && bus.tick && !bus.land_valid),
    .load_val (ROUND_TICKS),
    .count    (bus.timer),
    .expire   (expire)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.state <= IDLE;
      bus.score <= '0;
      bus.lives <= '0;
      bus.plat_colors <= '0;
      bus.ball_color <= '0;
      bus.round_hit <= 1'b0;
      bus.round_miss <= 1'b0;
      bus.game_over <= 1'b0;
    end else begin
      bus.round_hit <= 1'b0;
      bus.round_miss <= 1'b0;
      case (bus.state)
        IDLE, OVER: if (bus.start) begin
          bus.score <= '0;
          bus.lives <= START_LIVES;
          bus.game_over <= 1'b0;
          bus.state <= LOAD;
        end
        LOAD: begin
          bus.plat_colors <= bus.new_color_plats;
          bus.ball_color <= bus.new_color_ball;
          bus.state <= PLAY;
        end
        PLAY: if (bus.land_valid && match) begin
          bus.score <= &bus.score ? bus.score : bus.score + SCORE_W'(1);
          bus.round_hit <= 1'b1;
          bus.state <= LOAD;
        end else if (bus.land_valid || expire) begin
          bus.round_miss <= 1'b1;
          bus.lives <= bus.lives == 2'd0 ? 2'd0 : bus.lives - 2'd1;
          bus.game_over <= bus.lives == 2'd1;
          bus.state <= bus.lives == 2'd1 ? OVER : LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_color_round_ctrl.sv
// tb_color_round_ctrl: randomized games against a round-level reference model with a pulse/round scoreboard
module tb_color_round_ctrl;
  import color_round_ctrl_pkg::*;
  localparam logic [7:0] RT = 8'd120;
  localparam logic [1:0] SL = 2'd3;
  localparam int SW = 8;
  localparam int SMAX = (1 << SW) - 1;
  typedef struct {logic [11:0] pal; logic [2:0] ball; int timer; int lives; int score;} load_t;
  typedef struct {bit hit; int score; int lives; int timer; bit over;} res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  color_round_ctrl_if #(.SCORE_W(SW)) bus();
  color_round_ctrl #(.ROUND_TICKS(RT), .START_LIVES(SL), .SCORE_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  load_t load_q[$];
  res_t res_q[$];
  int checks = 0;
  int passes = 0;
  int lives, score, tl;
  logic [11:0] mpal;
  logic [2:0] mball;
  logic [11:0] cur_pal;
  logic [2:0] cur_ball;
  bit have_cur = 0;
  state_t prev = IDLE;
  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction
  function automatic logic [1:0] find_plat(bit want);
    for (int k = 0; k < 4; k++) if ((mpal[3*k +: 3] == mball) == want) return 2'(k);
    return 2'($urandom_range(0, 3));
  endfunction
  function automatic logic [11:0] rand_pal(logic [2:0] b);
    logic [11:0] p;
    int k;
    p = 12'($urandom);
    k = $urandom_range(0, 3);
    p[3*k +: 3] = b;
    return p;
  endfunction
  task automatic drive(bit st, bit tk, bit lv, logic [1:0] lp, logic [11:0] pal, logic [2:0] bl);
    @(negedge clk);
    bus.start = st;
    bus.tick = tk;
    bus.land_valid = lv;
    bus.land_plat = lp;
    bus.new_color_plats = pal;
    bus.new_color_ball = bl;
  endtask
  task automatic load_round(logic [11:0] pal, logic [2:0] bl);
    drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), pal, bl);
    mpal = pal;
    mball = bl;
    tl = RT;
    load_q.push_back('{pal, bl, int'(RT), lives, score});
  endtask
  task automatic rand_round();
    logic [2:0] b;
    b = 3'($urandom);
    load_round(rand_pal(b), b);
  endtask
  task automatic new_game(logic [11:0] pal, logic [2:0] bl);
    drive(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 12'($urandom), 3'($urandom));
    score = 0;
    lives = SL;
    load_round(pal, bl);
  endtask
  task automatic miss();
    lives = lives - 1;
    res_q.push_back('{1'b0, score, lives, tl, lives == 0});
  endtask
  task automatic step(bit tk, bit lv, logic [1:0] lp, output bit done);
    drive(1'($urandom), tk, lv, lp, 12'($urandom), 3'($urandom));
    done = 1'b0;
    if (lv) begin
      done = 1'b1;
      if (mpal[3*lp +: 3] == mball) begin
        score = score + 1 > SMAX ? SMAX : score + 1;
        res_q.push_back('{1'b1, score, lives, tl, 1'b0});
      end else miss();
    end else if (tk) begin
      if (tl == 1) begin
        tl = 0;
        done = 1'b1;
        miss();
      end else tl = tl - 1;
    end
  endtask
  task automatic play_round(int mode, output bit over);
    bit done = 1'b0;
    int n = 0;
    while (!done) begin
      case (mode)
        0: step(1'b1, 1'b0, 2'd0, done);
        1: step(1'($urandom), 1'b1, find_plat(1'b1), done);
        2: step(1'($urandom), n >= 1, find_plat(1'b0), done);
        3: step(1'b1, tl == 1, find_plat(1'b1), done);
        default: step(1'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), done);
      endcase
      n++;
    end
    over = lives == 0;
  endtask
  task automatic idle_over();
    repeat (3) drive(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 12'($urandom), 3'($urandom));
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_state"}, bus.state, IDLE);
    chk({tag, "_score"}, bus.score, 0);
    chk({tag, "_lives"}, bus.lives, 0);
    chk({tag, "_timer"}, bus.timer, 0);
    chk({tag, "_plats"}, bus.plat_colors, 0);
    chk({tag, "_ball"}, bus.ball_color, 0);
    chk({tag, "_hit"}, bus.round_hit, 0);
    chk({tag, "_miss"}, bus.round_miss, 0);
    chk({tag, "_over"}, bus.game_over, 0);
  endtask
  always @(negedge clk) begin
    if (reset) begin
      have_cur <= 0;
      prev <= IDLE;
    end else begin
      if (bus.round_hit || bus.round_miss) begin
        if (res_q.size() == 0) begin
          checks++;
          $display("FAIL pulse: got hit=%0b miss=%0b expected no outcome pending", bus.round_hit, bus.round_miss);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("round_hit", bus.round_hit, r.hit);
          chk("round_miss", bus.round_miss, !r.hit);
          chk("score", bus.score, r.score);
          chk("lives", bus.lives, r.lives);
          chk("timer_at_outcome", bus.timer, r.timer);
          chk("game_over", bus.game_over, r.over);
          chk("state_after_outcome", bus.state, r.over ? OVER : LOAD);
        end
      end
      if (bus.state == PLAY && prev != PLAY) begin
        if (load_q.size() == 0) begin
          checks++;
          $display("FAIL round_start: got PLAY expected no round pending");
        end else begin
          load_t l;
          l = load_q.pop_front();
          chk("plat_colors", bus.plat_colors, l.pal);
          chk("ball_color", bus.ball_color, l.ball);
          chk("timer_start", bus.timer, l.timer);
          chk("lives_start", bus.lives, l.lives);
          chk("score_start", bus.score, l.score);
          cur_pal <= l.pal;
          cur_ball <= l.ball;
          have_cur <= 1;
        end
      end else if (bus.state == PLAY && have_cur) begin
        chk("plats_stable", bus.plat_colors, cur_pal);
        chk("ball_stable", bus.ball_color, cur_ball);
      end
      prev <= bus.state;
    end
  end
  initial begin
    bit over, done;
    bus.start = 0;
    bus.tick = 0;
    bus.land_valid = 0;
    bus.land_plat = 0;
    bus.new_color_plats = 0;
    bus.new_color_ball = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    new_game(12'o7531, 3'd5);
    step(1'b0, 1'b1, 2'd2, done);
    load_round(12'o7531, 3'd5);
    step(1'b0, 1'b1, 2'd0, done);
    rand_round();
    play_round(0, over);
    rand_round();
    play_round(3, over);
    load_round(12'o7531, 3'd5);
    step(1'b1, 1'b1, 2'd3, done);
    idle_over();
    new_game(12'o1234, 3'd4);
    repeat (260) begin
      play_round(1, over);
      rand_round();
    end
    repeat (150) begin
      play_round($urandom_range(0, 7), over);
      if (over) begin
        idle_over();
        new_game(rand_pal(3'd6), 3'd6);
      end else rand_round();
    end
    step(1'b0, 1'b0, 2'd0, done);
    @(negedge clk);
    reset = 1;
    bus.start = 0;
    bus.tick = 0;
    bus.land_valid = 0;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 0;
    repeat (2) @(negedge clk);
    chk("pending_outcomes", res_q.size(), 0);
    chk("pending_rounds", load_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
